// File: rtl/mac_result_fifo_if.sv
// CSR bus and MAC result capture signals of mac_result_fifo.
// The master side is the MAC core plus the CSR adaptor; the slave side is the FIFO.
interface mac_result_fifo_if #(
   parameter int unsigned RESULT_WIDTH = 25,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 32
) ();
   logic [RESULT_WIDTH-1:0] result_rsc_dat;
   logic                    result_triosy_lz;
   logic [ADDR_WIDTH-1:0]   addr;
   logic                    ren;
   logic                    wen;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    raddr_error;
   logic                    waddr_error;
   logic                    irq;

   modport master (
      output result_rsc_dat, result_triosy_lz, addr, ren, wen, wdata,
      input  rdata, raddr_error, waddr_error, irq
   );

   modport slave (
      input  result_rsc_dat, result_triosy_lz, addr, ren, wen, wdata,
      output rdata, raddr_error, waddr_error, irq
   );
endinterface

// File: rtl/mac_result_fifo.sv
// Capture FIFO for MAC results with a CSR view (DATA/STATUS/CTRL/CLEAR) and a level interrupt.
// DATA reads pop the head; pushes come from the MAC valid strobe when capture is enabled.
module mac_result_fifo #(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned RESULT_WIDTH = 25,
   parameter int unsigned ADDR_WIDTH   = 12,
   parameter int unsigned DATA_WIDTH   = 32
) (
   input logic              clk,
   input logic              arst,
   mac_result_fifo_if.slave bus
);
   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned WordW = ADDR_WIDTH - 2;

   logic [RESULT_WIDTH-1:0] mem_q [DEPTH];

   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  cap_en_q, cap_en_d;
   logic                  irq_en_q, irq_en_d;
   logic [7:0]            thresh_q, thresh_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  raddr_error_q, raddr_error_d;
   logic                  waddr_error_q, waddr_error_d;

   logic [WordW-1:0]        word;
   logic                    sel_data, sel_status, sel_ctrl, sel_clear, sel_unmapped;
   logic                    empty, full;
   logic [7:0]              count8;
   logic [RESULT_WIDTH-1:0] head;
   logic [DATA_WIDTH-1:0]   head_ext, status_val, ctrl_val;
   logic                    pop, push_req, push, flush, ovf_set, unf_set, clr_ovf, clr_unf;
   logic                    unused_bits;

   // Byte-address bits [1:0] never take part in decode.
   assign word         = bus.addr[ADDR_WIDTH-1:2];
   assign sel_data     = (word == WordW'(0));
   assign sel_status   = (word == WordW'(1));
   assign sel_ctrl     = (word == WordW'(2));
   assign sel_clear    = (word == WordW'(3));
   assign sel_unmapped = (word > WordW'(3));
   assign unused_bits  = ^{bus.addr[1:0], bus.wdata};

   assign empty  = (count_q == CntW'(0));
   assign full   = (count_q == CntW'(DEPTH));
   assign count8 = 8'(count_q);

   assign head       = mem_q[rd_ptr_q];
   assign head_ext   = DATA_WIDTH'($signed(head));
   assign status_val = DATA_WIDTH'({unf_q, ovf_q, 6'b0, full, empty, count8});
   assign ctrl_val   = DATA_WIDTH'({thresh_q, 6'b0, irq_en_q, cap_en_q});

   always_comb begin
      pop      = bus.ren & sel_data & ~empty;
      unf_set  = bus.ren & sel_data & empty;
      flush    = bus.wen & sel_clear & bus.wdata[0];
      clr_ovf  = bus.wen & sel_clear & bus.wdata[1];
      clr_unf  = bus.wen & sel_clear & bus.wdata[2];
      push_req = bus.result_triosy_lz & cap_en_q;
      // A flush swallows a coincident sample without flagging it as an overflow.
      push     = push_req & ~flush & (~full | pop);
      ovf_set  = push_req & ~flush & full & ~pop;
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         count_d = count_q + CntW'(push) - CntW'(pop);
      end

      ovf_d = ovf_set | (ovf_q & ~clr_ovf);
      unf_d = unf_set | (unf_q & ~clr_unf);

      cap_en_d = cap_en_q;
      irq_en_d = irq_en_q;
      thresh_d = thresh_q;
      if (bus.wen && sel_ctrl) begin
         cap_en_d = bus.wdata[0];
         irq_en_d = bus.wdata[1];
         thresh_d = bus.wdata[15:8];
      end
   end

   // Reads see pre-write state; rdata holds between reads.
   always_comb begin
      rdata_d       = rdata_q;
      raddr_error_d = 1'b0;
      if (bus.ren) begin
         if (sel_data) begin
            rdata_d = empty ? '0 : head_ext;
         end else if (sel_status) begin
            rdata_d = status_val;
         end else if (sel_ctrl) begin
            rdata_d = ctrl_val;
         end else begin
            rdata_d       = '0;
            raddr_error_d = sel_unmapped;
         end
      end
      waddr_error_d = bus.wen & (sel_data | sel_status | sel_unmapped);
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         cap_en_q      <= 1'b0;
         irq_en_q      <= 1'b0;
         thresh_q      <= 8'd1;
         ovf_q         <= 1'b0;
         unf_q         <= 1'b0;
         rdata_q       <= '0;
         raddr_error_q <= 1'b0;
         waddr_error_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         cap_en_q      <= cap_en_d;
         irq_en_q      <= irq_en_d;
         thresh_q      <= thresh_d;
         ovf_q         <= ovf_d;
         unf_q         <= unf_d;
         rdata_q       <= rdata_d;
         raddr_error_q <= raddr_error_d;
         waddr_error_q <= waddr_error_d;
      end
   end

   // Storage array carries no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.result_rsc_dat;
      end
   end

   assign bus.rdata       = rdata_q;
   assign bus.raddr_error = raddr_error_q;
   assign bus.waddr_error = waddr_error_q;
   assign bus.irq         = irq_en_q & (((thresh_q != 8'd0) & (count8 >= thresh_q)) | ovf_q);
endmodule

// File: tb/tb_mac_result_fifo.sv
// Randomised scoreboard bench for mac_result_fifo against a queue-based reference model.
module tb_mac_result_fifo;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned RW    = 25;
   localparam int unsigned AW    = 12;

   typedef struct {
      bit          is_rd;
      bit          is_wr;
      logic [31:0] rdata;
      bit          rerr;
      bit          werr;
   } exp_t;

   logic clk = 1'b0;
   logic arst;
   int   n_checks = 0;
   int   n_err    = 0;

   mac_result_fifo_if #(.RESULT_WIDTH(RW), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

   mac_result_fifo #(
      .DEPTH(DEPTH), .RESULT_WIDTH(RW), .ADDR_WIDTH(AW), .DATA_WIDTH(32)
   ) dut (
      .clk (clk),
      .arst(arst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [RW-1:0] mq[$];
   bit            m_cap, m_ien, m_ovf, m_unf;
   int            m_thr;
   exp_t          sb[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sext(logic [RW-1:0] v);
      return 32'($signed(v));
   endfunction

   function automatic bit model_irq();
      return m_ien && (((m_thr != 0) && (mq.size() >= m_thr)) || m_ovf);
   endfunction

   function automatic logic [31:0] model_status();
      int c = mq.size();
      return 32'(c) + ((c == 0) ? 32'h100 : 0) + ((c == DEPTH) ? 32'h200 : 0)
             + (m_ovf ? 32'h1_0000 : 0) + (m_unf ? 32'h2_0000 : 0);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cap = 0; m_ien = 0; m_ovf = 0; m_unf = 0; m_thr = 1;
   endtask

   task automatic model_step(bit push, logic [RW-1:0] val, bit rd, bit wr, logic [AW-1:0] a,
                             logic [31:0] wd, output exp_t e);
      int  w   = int'(a[AW-1:2]);
      int  cnt = mq.size();
      bit  pop, ovf_set, unf_set;
      e.is_rd = rd; e.is_wr = wr; e.rdata = 0; e.rerr = 0; e.werr = 0;
      if (rd) begin
         case (w)
            0:       e.rdata = (cnt > 0) ? sext(mq[0]) : 32'h0;
            1:       e.rdata = model_status();
            2:       e.rdata = 32'(m_thr) * 256 + (m_ien ? 2 : 0) + (m_cap ? 1 : 0);
            3:       e.rdata = 0;
            default: e.rerr = 1;
         endcase
      end
      e.werr  = wr && (w == 0 || w == 1 || w >= 4);
      pop     = rd && w == 0 && cnt > 0;
      unf_set = rd && w == 0 && cnt == 0;
      ovf_set = 0;
      if (wr && w == 3 && wd[0]) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (push && m_cap) begin
            if (cnt == DEPTH && !pop) ovf_set = 1;
            else mq.push_back(val);
         end
      end
      m_ovf = ovf_set || (m_ovf && !(wr && w == 3 && wd[1]));
      m_unf = unf_set || (m_unf && !(wr && w == 3 && wd[2]));
      if (wr && w == 2) begin
         m_cap = wd[0]; m_ien = wd[1]; m_thr = int'(wd[15:8]);
      end
   endtask

   // One bus cycle: drive at posedge+1, predict, then check irq after the edge.
   task automatic cycle(bit push, logic [RW-1:0] val, bit rd, bit wr, logic [AW-1:0] a,
                        logic [31:0] wd);
      exp_t e;
      bus.result_triosy_lz = push;
      bus.result_rsc_dat   = val;
      bus.ren              = rd;
      bus.wen              = wr;
      bus.addr             = a;
      bus.wdata            = wd;
      model_step(push, val, rd, wr, a, wd, e);
      if (rd || wr) sb.push_back(e);
      @(posedge clk);
      #1;
      chk("irq", {31'b0, bus.irq}, {31'b0, model_irq()});
   endtask

   task automatic rd(logic [AW-1:0] a);             cycle(0, '0, 1, 0, a, '0); endtask
   task automatic wr(logic [AW-1:0] a, logic [31:0] d); cycle(0, '0, 0, 1, a, d); endtask
   task automatic push(logic [RW-1:0] v);           cycle(1, v, 0, 0, '0, '0); endtask
   task automatic idle();                           cycle(0, '0, 0, 0, '0, '0); endtask

   // Monitor: compare the registered response one cycle after each access.
   bit acc_q = 0;
   always @(posedge clk) acc_q = bus.ren | bus.wen;

   always @(negedge clk) begin
      exp_t e;
      if (!arst) begin
         if (acc_q) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL sb_underrun: got response expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               if (e.is_rd) chk("rdata", bus.rdata, e.rdata);
               chk("raddr_error", {31'b0, bus.raddr_error}, {31'b0, e.rerr});
               chk("waddr_error", {31'b0, bus.waddr_error}, {31'b0, e.werr});
            end
         end else begin
            chk("raddr_error_idle", {31'b0, bus.raddr_error}, 32'h0);
            chk("waddr_error_idle", {31'b0, bus.waddr_error}, 32'h0);
         end
      end
   end

   initial begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      arst = 1'b1;
      bus.result_triosy_lz = 0; bus.result_rsc_dat = '0; bus.ren = 0; bus.wen = 0;
      bus.addr = '0; bus.wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_raddr_error", {31'b0, bus.raddr_error}, 32'h0);
      chk("rst_waddr_error", {31'b0, bus.waddr_error}, 32'h0);
      chk("rst_irq", {31'b0, bus.irq}, 32'h0);
      arst = 1'b0;

      rd(12'h004);
      rd(12'h008);

      // Sign extension
      wr(12'h008, 32'h0000_0101);
      push(25'd5); push(25'h1FF_FFFF); push(25'h0FF_FFFF);
      rd(12'h000); rd(12'h000); rd(12'h000); rd(12'h004);

      // Overflow, clear, then full push+pop streaming
      for (int i = 0; i < 17; i++) push(RW'($urandom));
      rd(12'h004);
      wr(12'h00C, 32'h2);
      rd(12'h004);
      for (int i = 0; i < 40; i++) cycle(1, RW'($urandom), 1, 0, 12'h000, '0);
      rd(12'h004);
      for (int i = 0; i < 16; i++) rd(12'h000);
      rd(12'h004);

      // Threshold interrupt, then THRESH=0 with overflow
      wr(12'h008, 32'h0000_0403);
      for (int i = 0; i < 4; i++) push(RW'($urandom));
      rd(12'h000);
      wr(12'h008, 32'h0000_0003);
      for (int i = 0; i < 15; i++) push(RW'($urandom));
      rd(12'h004);
      wr(12'h00C, 32'h7);

      // Bus errors and simultaneous events
      rd(12'h000); rd(12'h004);
      rd(12'h020);
      wr(12'h004, 32'hFFFF_FFFF);
      wr(12'h000, 32'h1234_5678);
      rd(12'h004);
      wr(12'h00C, 32'h4);
      cycle(0, '0, 1, 1, 12'h008, 32'h0000_0201);
      rd(12'h008);
      cycle(1, 25'h0AB_CDEF, 1, 0, 12'h000, '0);
      rd(12'h000);
      push(25'd1); push(25'd2);
      cycle(1, 25'd3, 0, 1, 12'h00C, 32'h1);
      rd(12'h004);
      for (int i = 0; i < 16; i++) push(RW'($urandom));
      cycle(1, 25'd9, 0, 1, 12'h00C, 32'h2);
      rd(12'h004);
      cycle(1, 25'd7, 1, 1, 12'h00C, 32'h1);
      rd(12'h004);

      // Reset with entries queued and irq high
      wr(12'h008, 32'h0000_0403);
      for (int i = 0; i < 5; i++) push(RW'($urandom));
      idle();
      #2;
      arst = 1'b1;
      #1;
      chk("arst_irq", {31'b0, bus.irq}, 32'h0);
      chk("arst_rdata", bus.rdata, 32'h0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      model_reset();
      rd(12'h004);
      rd(12'h008);

      // Random traffic
      wr(12'h008, 32'h0000_0301);
      for (int i = 0; i < 600; i++) begin
         bit p, r, w;
         p = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         w = ($urandom_range(0, 99) < 8);
         a = AW'($urandom_range(0, 5) * 4 + $urandom_range(0, 3));
         if (r && $urandom_range(0, 1) == 1) a = AW'($urandom_range(0, 3));
         d = $urandom;
         if (a[AW-1:2] == 2 && $urandom_range(0, 9) != 0) d[0] = 1'b1;
         if (a[AW-1:2] == 3 && $urandom_range(0, 3) != 0) d[0] = 1'b0;
         cycle(p, RW'($urandom), r, w, a, d);
      end
      idle(); idle();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/mac_result_fifo.md
# mac_result_fifo

Capture buffer directly downstream of the `mac` HLS core: each cycle the core flags a valid `result_rsc_dat` (via `result_triosy_lz`), the value is pushed into a DEPTH-entry FIFO. The FIFO, its status and an interrupt are exposed on the same simple CSR bus (`addr/ren/wen/rdata/wdata/*_error`) that the AXI4-lite adaptor drives. Software can therefore drain a burst of MAC results without having to poll each one before the next arrives.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of 2, 2..128
- RESULT_WIDTH, 25, width of `result_rsc_dat`; signed two's complement; at most 32
- ADDR_WIDTH, 12, CSR byte-address width
- DATA_WIDTH, 32, CSR data width; fixed at 32

Ports:
- clk  in  1  single clock for all logic
- arst  in  1  asynchronous, active-high reset
- result_rsc_dat  in  RESULT_WIDTH  MAC result
- result_triosy_lz  in  1  result-valid strobe; one capture per high cycle
- addr  in  ADDR_WIDTH  CSR byte address; bits [1:0] are ignored
- ren  in  1  read strobe; one access per high cycle
- wen  in  1  write strobe; one access per high cycle
- wdata  in  32  write data
- rdata  out  32  read data, registered
- raddr_error  out  1  unmapped read, registered alongside `rdata`
- waddr_error  out  1  unmapped or read-only write, registered
- irq  out  1  level interrupt

## Operation
Register map (byte offsets):
- 0x000 DATA (RO): a read returns the head entry sign-extended to 32 bits and pops it. If the FIFO is empty, the read returns 0, sets the UNDERFLOW sticky bit and does not pop.
- 0x004 STATUS (RO):
  - [7:0] COUNT
  - [8] EMPTY
  - [9] FULL
  - [16] OVERFLOW sticky
  - [17] UNDERFLOW sticky
- 0x008 CTRL (RW):
  - [0] CAP_EN, reset 0
  - [1] IRQ_EN, reset 0
  - [15:8] THRESH, reset 1
  - all other bits read 0
- 0x00C CLEAR (WO, self-clearing):
  - [0] flush FIFO
  - [1] clear OVERFLOW
  - [2] clear UNDERFLOW
  - reads return 0 with no error

Error rules:
- A write to 0x000 or 0x004 is ignored and sets waddr_error.
- Any other offset ≥ 0x010 reads 0 with raddr_error, and a write there is ignored with waddr_error.

Capture:
- A push occurs when `result_triosy_lz` & CAP_EN.
- When the FIFO is full and no pop happens in the same cycle, the sample is dropped and OVERFLOW is set.

Storage:
- Circular buffer with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH.
- A separate COUNT of 0..DEPTH is kept.
- EMPTY = (COUNT==0); FULL = (COUNT==DEPTH).

Interrupt: `irq` = IRQ_EN & ((THRESH!=0 & COUNT≥THRESH) | OVERFLOW). It is combinational from registered state only, so it is glitch-free.

Simultaneous events:
- Push + pop when full: both take effect, COUNT is unchanged, no overflow.
- Push + pop when empty: the pop returns 0 and sets UNDERFLOW; the push is stored. There is no bypass.
- Flush + push in the same cycle: flush wins, the sample is dropped, and OVERFLOW is not set.
- A CLEAR write setting [1] in the same cycle as a new overflow leaves OVERFLOW set, because set has priority over clear. The same applies to UNDERFLOW.
- `ren` and `wen` in the same cycle: both are serviced, and the read returns pre-write state.

Reset (arst high, any cycle):
- rdata=0, raddr_error=0, waddr_error=0, irq=0.
- Pointers and COUNT are 0, sticky bits are 0, and CTRL takes its reset values.
- FIFO RAM contents are not reset and are undefined.
- Reset mid-burst discards all queued entries.

## Timing
- Push: a strobe in cycle N is visible in COUNT and STATUS from cycle N+1; `irq` can rise in N+1.
- Read: `ren` in cycle N gives `rdata`/`raddr_error` valid in cycle N+1. The pop takes effect at the same edge, so a STATUS read issued in N+1 shows the decremented COUNT.
- `rdata` holds its last value when no read occurs. `raddr_error` is a one-cycle pulse.
- Write: `wen` in cycle N updates the register at the end of N. `waddr_error` pulses in cycle N+1.
- Throughput: one push and one pop per cycle are sustainable indefinitely.

## Test plan
- Reset, then read STATUS → 0x00000100 (EMPTY). Read CTRL → 0x00000100. `irq`=0.
- CAP_EN=1, push 3 strobes with values 5, -1 (0x1FFFFFF), 0x0FFFFFF. Read DATA ×3 → 0x00000005, 0xFFFFFFFF, 0x00FFFFFF. STATUS → EMPTY.
- Push 17 with DEPTH=16 → COUNT=16, FULL=1, OVERFLOW=1, and entry 17 is lost. Then write CLEAR=0x2 → OVERFLOW=0, data intact.
- When full, push and DATA read in the same cycle → COUNT stays 16, no overflow, and the pointers wrap correctly over 40 cycles of back-to-back traffic (scoreboard order).
- IRQ_EN=1, THRESH=4: `irq` is low at COUNT 3 and rises the cycle after the 4th push. A DATA read drops `irq`. THRESH=0 gives no irq unless OVERFLOW is set.
- Bus errors and reset:
  - Read from empty → rdata 0, UNDERFLOW set.
  - Read 0x020 → raddr_error pulse.
  - Write 0x004 → waddr_error pulse, state unchanged.
  - Assert `arst` with 5 entries queued → COUNT 0 and flags 0 immediately.
